dram_refresh_sched: RTL and testbench

Synchronous scheduler for the DRAM refresh path. It divides the system clock with a two-stage counter cascade (prescaler plus tick counter) to produce periodic refresh requests. It queues up to MAX_PENDING of those requests and arbitrates each one against CPU memory cycles. It drives the RAS-only refresh strobe and the 8-bit refresh row address, and sits between the CPU memory-request logic and the DRAM timing logic.

---
 rtl/dram_refresh_sched_pkg.sv | 18 +
 rtl/dram_refresh_sched_timer.sv | 46 ++++
 rtl/dram_refresh_sched.sv | 114 +++++++++++
 tb/tb_dram_refresh_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_refresh_sched_pkg.sv
// Shared definitions for the DRAM refresh scheduler:
// FSM encodings, output widths and a counter-width helper.
package dram_refresh_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU     = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  localparam int ADDR_W = 8;
  localparam int PEND_W = 2;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dram_refresh_sched_timer.sv
// Prescaler plus tick-counter cascade producing a
// registered one-clock refresh request pulse.
module refresh_timer
  import dram_refresh_sched_pkg::*;
#(
  parameter int PRESCALE = 16,
  parameter int TICKS    = 15
) (
  input  logic clk,
  input  logic reset,
  output logic req_pulse
);

  localparam int PW = cnt_w(PRESCALE);
  localparam int TW = cnt_w(TICKS);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TICKS - 1);

  logic [PW-1:0] r_pre;
  logic [TW-1:0] r_tick;
  logic          r_pulse;
  logic          w_wrap;
  logic          w_tick_last;

  assign w_wrap      = (r_pre == P_LAST);
  assign w_tick_last = (r_tick == T_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_tick  <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_wrap && w_tick_last;
      if (w_wrap) begin
        r_pre  <= '0;
        r_tick <= w_tick_last ? '0 : r_tick + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign req_pulse = r_pulse;

endmodule

// File: rtl/dram_refresh_sched.sv
// Refresh request queue and CPU/refresh arbiter driving the
// RAS-only refresh strobe and the refresh row address.
module dram_refresh_sched
  import dram_refresh_sched_pkg::*;
#(
  parameter int PRESCALE    = 16,
  parameter int TICKS       = 15,
  parameter int RAS_CYCLES  = 4,
  parameter int MAX_PENDING = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_done,
  output logic              cpu_gnt,
  output logic              ref_act,
  output logic [ADDR_W-1:0] ref_addr,
  output logic [PEND_W-1:0] ref_pending,
  output logic              ref_overrun
);

  localparam int RW = cnt_w(RAS_CYCLES);
  localparam logic [RW-1:0] RAS_LOAD = RW'(RAS_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  state_t            r_state;
  logic [RW-1:0]     r_ras;
  logic              r_gnt;
  logic              r_act;
  logic [ADDR_W-1:0] r_addr;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovr;

  logic w_req;
  logic w_done;
  logic w_full;
  logic w_go_ref;

  refresh_timer #(
    .PRESCALE (PRESCALE),
    .TICKS    (TICKS)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .req_pulse (w_req)
  );

  assign w_done   = (r_state == ST_REFRESH) && (r_ras == '0);
  assign w_full   = (r_pend == PEND_MAX);
  // A full queue beats the CPU; otherwise the CPU goes first.
  assign w_go_ref = w_full || (!cpu_req && (r_pend != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_ovr  <= 1'b0;
    end else if (w_req && !w_done) begin
      if (w_full) r_ovr <= 1'b1;
      else        r_pend <= r_pend + 1'b1;
    end else if (!w_req && w_done) begin
      r_pend <= r_pend - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ras   <= '0;
      r_gnt   <= 1'b0;
      r_act   <= 1'b0;
      r_addr  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_go_ref) begin
            r_state <= ST_REFRESH;
            r_act   <= 1'b1;
            r_ras   <= RAS_LOAD;
          end else if (cpu_req) begin
            r_state <= ST_CPU;
            r_gnt   <= 1'b1;
          end
        end
        ST_CPU: begin
          if (cpu_done) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
          end
        end
        ST_REFRESH: begin
          if (r_ras == '0) begin
            r_state <= ST_IDLE;
            r_act   <= 1'b0;
            r_addr  <= r_addr + 1'b1;
          end else begin
            r_ras <= r_ras - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 1'b0;
          r_act   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_gnt     = r_gnt;
  assign ref_act     = r_act;
  assign ref_addr    = r_addr;
  assign ref_pending = r_pend;
  assign ref_overrun = r_ovr;

endmodule

// File: tb/tb_dram_refresh_sched.sv
// Bench for dram_refresh_sched: cycle-indexed vector table
// with a scoreboard queue, plus wrap and reset sequences.
module tb_dram_refresh_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req;
  logic       cpu_done;
  logic       cpu_gnt;
  logic       ref_act;
  logic [7:0] ref_addr;
  logic [1:0] ref_pending;
  logic       ref_overrun;

  dram_refresh_sched #(
    .PRESCALE    (4),
    .TICKS       (2),
    .RAS_CYCLES  (3),
    .MAX_PENDING (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_done    (cpu_done),
    .cpu_gnt     (cpu_gnt),
    .ref_act     (ref_act),
    .ref_addr    (ref_addr),
    .ref_pending (ref_pending),
    .ref_overrun (ref_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       req;
    logic       done;
    logic       gnt;
    logic       act;
    logic [1:0] pend;
    logic [7:0] addr;
    logic       ovr;
  } vec_t;

  typedef struct {
    logic       gnt;
    logic       act;
    logic [1:0] pend;
    logic [7:0] addr;
    logic       ovr;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   overlap = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_gnt && ref_act) overlap++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_done = 1'b0;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic push_exp(input logic g, input logic a,
                          input logic [1:0] p,
                          input logic [7:0] ad,
                          input logic o);
    exp_t e;
    e.gnt  = g;
    e.act  = a;
    e.pend = p;
    e.addr = ad;
    e.ovr  = o;
    sbq.push_back(e);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s cyc=%0d scoreboard empty", name, cyc);
    end else begin
      e = sbq.pop_front();
      if (cpu_gnt !== e.gnt || ref_act !== e.act ||
          ref_pending !== e.pend || ref_addr !== e.addr ||
          ref_overrun !== e.ovr) begin
        errors++;
        $display("FAIL %s cyc=%0d got gnt=%b act=%b pend=%0d addr=%0d ovr=%b exp gnt=%b act=%b pend=%0d addr=%0d ovr=%b",
                 name, cyc, cpu_gnt, ref_act, ref_pending,
                 ref_addr, ref_overrun, e.gnt, e.act, e.pend,
                 e.addr, e.ovr);
      end
    end
  endtask

  task automatic add(input int c, input logic rq,
                     input logic dn, input logic g,
                     input logic a, input logic [1:0] p,
                     input logic [7:0] ad, input logic o);
    vec_t v;
    v.cyc  = c;
    v.req  = rq;
    v.done = dn;
    v.gnt  = g;
    v.act  = a;
    v.pend = p;
    v.addr = ad;
    v.ovr  = o;
    vecs.push_back(v);
  endtask

  initial begin
    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_done = 1'b0;

    // refresh only; stray cpu_done while idle
    add(-1, 0, 0, 0, 0, 0, 0, 0);
    add( 0, 0, 0, 0, 0, 0, 0, 0);
    add( 4, 0, 1, 0, 0, 0, 0, 0);
    add( 5, 0, 0, 0, 0, 0, 0, 0);
    add( 8, 0, 0, 0, 0, 0, 0, 0);
    add( 9, 0, 0, 0, 0, 1, 0, 0);
    add(10, 0, 0, 0, 1, 1, 0, 0);
    add(12, 0, 0, 0, 1, 1, 0, 0);
    add(13, 0, 0, 0, 0, 0, 1, 0);
    add(17, 0, 0, 0, 0, 1, 1, 0);
    add(18, 0, 0, 0, 1, 1, 1, 0);
    add(20, 0, 0, 0, 1, 1, 1, 0);
    add(21, 0, 0, 0, 0, 0, 2, 0);
    // CPU cycle then refresh; event meets completion at 17
    add(-1, 0, 0, 0, 0, 0, 0, 0);
    add( 0, 0, 0, 0, 0, 0, 0, 0);
    add( 2, 1, 0, 0, 0, 0, 0, 0);
    add( 3, 0, 0, 1, 0, 0, 0, 0);
    add( 8, 0, 0, 1, 0, 0, 0, 0);
    add( 9, 0, 0, 1, 0, 1, 0, 0);
    add(12, 0, 1, 1, 0, 1, 0, 0);
    add(13, 0, 0, 0, 0, 1, 0, 0);
    add(14, 0, 0, 0, 1, 1, 0, 0);
    add(16, 0, 0, 0, 1, 1, 0, 0);
    add(17, 0, 0, 0, 0, 1, 1, 0);
    add(18, 0, 0, 0, 1, 1, 1, 0);
    add(21, 0, 0, 0, 0, 0, 2, 0);
    // pending==1 with cpu_req: CPU wins
    add(-1, 0, 0, 0, 0, 0, 0, 0);
    add( 0, 0, 0, 0, 0, 0, 0, 0);
    add( 9, 1, 0, 0, 0, 1, 0, 0);
    add(10, 0, 1, 1, 0, 1, 0, 0);
    add(11, 0, 0, 0, 0, 1, 0, 0);
    add(12, 0, 0, 0, 1, 1, 0, 0);
    add(15, 0, 0, 0, 0, 0, 1, 0);
    // long CPU hold: overrun, full queue beats cpu_req
    add(-1, 0, 0, 0, 0, 0, 0, 0);
    add( 0, 0, 0, 0, 0, 0, 0, 0);
    add( 2, 1, 0, 0, 0, 0, 0, 0);
    add( 3, 0, 0, 1, 0, 0, 0, 0);
    add(25, 0, 0, 1, 0, 3, 0, 0);
    add(32, 0, 0, 1, 0, 3, 0, 0);
    add(33, 0, 0, 1, 0, 3, 0, 1);
    add(34, 0, 1, 1, 0, 3, 0, 1);
    add(35, 1, 0, 0, 0, 3, 0, 1);
    add(36, 0, 0, 0, 1, 3, 0, 1);
    add(39, 0, 0, 0, 0, 2, 1, 1);
    add(40, 0, 0, 0, 1, 2, 1, 1);
    add(41, 0, 0, 0, 1, 3, 1, 1);
    add(43, 0, 0, 0, 0, 2, 2, 1);
    add(44, 0, 0, 0, 1, 2, 2, 1);
    add(47, 0, 0, 0, 0, 1, 3, 1);
    add(48, 0, 0, 0, 1, 1, 3, 1);

    foreach (vecs[i]) begin
      if (vecs[i].cyc < 0) begin
        do_reset();
      end else begin
        push_exp(vecs[i].gnt, vecs[i].act, vecs[i].pend,
                 vecs[i].addr, vecs[i].ovr);
        run_to(vecs[i].cyc);
        check_out($sformatf("vec%0d", i));
        cpu_req  = vecs[i].req;
        cpu_done = vecs[i].done;
      end
    end

    // row address wrap after 256 refreshes, then reset mid-refresh
    do_reset();
    push_exp(0, 1, 1, 8'd255, 0);
    run_to(2052);
    check_out("addr_255");
    push_exp(0, 0, 0, 8'd0, 0);
    run_to(2053);
    check_out("addr_wrap");
    push_exp(0, 1, 1, 8'd0, 0);
    run_to(2058);
    check_out("refresh_before_rst");
    reset = 1'b1;
    push_exp(0, 0, 0, 8'd0, 0);
    run_to(2059);
    check_out("rst_mid_refresh");
    reset = 1'b0;

    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL no_overlap got %0d overlapping cycles exp 0",
               overlap);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
